// File: rtl/lsu_tlb_wrdp_pkg.sv
// Field positions, page-size encodings and FSM states shared by the DTLB write datapath.
package lsu_tlb_wrdp_pkg;

    localparam int STLB_TAG_W  = 59;
    localparam int STLB_DATA_W = 43;

    localparam int STLB_TAG_V          = 58;
    localparam int STLB_TAG_VA_27_22_V = 57;
    localparam int STLB_TAG_VA_21_16_V = 56;
    localparam int STLB_TAG_VA_15_13_V = 55;
    localparam int STLB_TAG_PARITY     = 54;
    localparam int STLB_TAG_VA_HI      = 53;
    localparam int STLB_TAG_VA_LO      = 28;
    localparam int STLB_TAG_U          = 26;
    localparam int STLB_TAG_VA_LO_HI   = 21;
    localparam int STLB_TAG_VA_LO_LO   = 13;
    localparam int STLB_TAG_CTXT_HI    = 12;

    // Covered: [58:55], [53:27], [25], [23:0]; matches the read-side checker.
    localparam logic [STLB_TAG_W-1:0] STLB_TAG_PAR_MASK =
        {4'hF, 1'b0, 27'h7FF_FFFF, 1'b0, 1'b1, 1'b0, 24'hFF_FFFF};

    localparam int STLB_DATA_PARITY    = 42;
    localparam int STLB_DATA_NFO       = 41;
    localparam int STLB_DATA_IE        = 40;
    localparam int STLB_DATA_PA_HI     = 39;
    localparam int STLB_DATA_PA_LO     = 13;
    localparam int STLB_DATA_27_22_SEL = 12;
    localparam int STLB_DATA_21_16_SEL = 11;
    localparam int STLB_DATA_15_13_SEL = 10;
    localparam int STLB_DATA_L         = 5;
    localparam int STLB_DATA_CP        = 4;
    localparam int STLB_DATA_CV        = 3;
    localparam int STLB_DATA_E         = 2;
    localparam int STLB_DATA_P         = 1;
    localparam int STLB_DATA_W_BIT     = 0;

    localparam logic [2:0] PSZ_8K   = 3'b000;
    localparam logic [2:0] PSZ_64K  = 3'b001;
    localparam logic [2:0] PSZ_4M   = 3'b011;
    localparam logic [2:0] PSZ_256M = 3'b101;

    localparam logic [2:0] SEL_8K   = 3'b000;
    localparam logic [2:0] SEL_64K  = 3'b001;
    localparam logic [2:0] SEL_4M   = 3'b011;
    localparam logic [2:0] SEL_256M = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FMT  = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/lsu_tlb_wr_fmt.sv
// Combinational formatter: ASI store data + Tag-Access value -> raw TLB tag/data words with parity.
module lsu_tlb_wr_fmt
    import lsu_tlb_wrdp_pkg::*;
(
    input  logic [63:0]             data,
    input  logic [63:0]             tag_acc,
    output logic [STLB_TAG_W-1:0]   tag,
    output logic [STLB_DATA_W-1:0]  dword,
    output logic                    sz_err
);

    logic [2:0] sz;
    logic [2:0] sel;
    logic       unused_bits;

    assign sz = {data[48], data[62:61]};
    assign unused_bits = ^{data[58:49], data[47:40], data[12:7], data[0], tag_acc[63:48]};

    always_comb begin
        sel    = SEL_8K;
        sz_err = 1'b0;
        case (sz)
            PSZ_8K:   sel = SEL_8K;
            PSZ_64K:  sel = SEL_64K;
            PSZ_4M:   sel = SEL_4M;
            PSZ_256M: sel = SEL_256M;
            default:  sz_err = 1'b1;   // reserved sizes fall back to 8K
        endcase
    end

    always_comb begin
        tag = '0;
        tag[STLB_TAG_V]                          = data[63];
        tag[STLB_TAG_VA_27_22_V]                 = sel[2];
        tag[STLB_TAG_VA_21_16_V]                 = sel[1];
        tag[STLB_TAG_VA_15_13_V]                 = sel[0];
        tag[STLB_TAG_VA_HI:STLB_TAG_VA_LO]       = tag_acc[47:22];
        tag[STLB_TAG_VA_LO_HI:STLB_TAG_VA_LO_LO] = tag_acc[21:13];
        tag[STLB_TAG_CTXT_HI:0]                  = tag_acc[12:0];
        tag[STLB_TAG_U]                          = 1'b0;
        tag[STLB_TAG_PARITY]                     = ^(tag & STLB_TAG_PAR_MASK);
    end

    always_comb begin
        dword = '0;
        dword[STLB_DATA_NFO]                     = data[60];
        dword[STLB_DATA_IE]                      = data[59];
        dword[STLB_DATA_PA_HI:STLB_DATA_PA_LO]   = data[39:13];
        dword[STLB_DATA_27_22_SEL]               = sel[2];
        dword[STLB_DATA_21_16_SEL]               = sel[1];
        dword[STLB_DATA_15_13_SEL]               = sel[0];
        dword[STLB_DATA_L]                       = data[6];
        dword[STLB_DATA_CP]                      = data[5];
        dword[STLB_DATA_CV]                      = data[4];
        dword[STLB_DATA_E]                       = data[3];
        dword[STLB_DATA_P]                       = data[2];
        dword[STLB_DATA_W_BIT]                   = data[1];
        dword[STLB_DATA_PARITY]                  = ^dword[STLB_DATA_PARITY-1:0];
    end

endmodule

// File: rtl/lsu_tlb_wrdp.sv
// DTLB write datapath: per-thread Tag-Access registers, snapshot/format/request FSM.
// Optional parity-error injection ports are enabled by defining LSU_TLB_PERR_INJ_EN.
module lsu_tlb_wrdp
    import lsu_tlb_wrdp_pkg::*;
#(
    parameter int THREADS = 4,
    parameter int TID_W   = 2,
    parameter int IDX_W   = 6
) (
    input  logic                    rclk,
    input  logic                    arst_l,
    input  logic                    tag_acc_wr_vld,
    input  logic [TID_W-1:0]        tag_acc_wr_tid,
    input  logic [63:0]             asi_wr_data,
    input  logic                    data_wr_vld,
    input  logic [TID_W-1:0]        data_wr_tid,
    input  logic                    data_wr_acc,
    input  logic [IDX_W-1:0]        data_wr_idx,
    output logic                    wr_busy,
    output logic                    tlb_wr_vld,
    input  logic                    tlb_wr_rdy,
    output logic [STLB_TAG_W-1:0]   tlb_wr_tag,
    output logic [STLB_DATA_W-1:0]  tlb_wr_data,
    output logic [IDX_W-1:0]        tlb_wr_idx,
    output logic                    tlb_wr_idx_vld,
    output logic                    tlb_wr_done,
    output logic                    tlb_wr_sz_err
`ifdef LSU_TLB_PERR_INJ_EN
    ,
    input  logic                    perr_inj_tag,
    input  logic                    perr_inj_data
`endif
);

    // Handshake: tlb_wr_vld rises in REQ and holds tag/data/idx stable until the
    // cycle tlb_wr_rdy is sampled high; that edge completes the transfer.
    state_e                  state;
    logic [63:0]             tag_acc [THREADS];
    logic [63:0]             data_q;
    logic [63:0]             tacc_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    acc_q;
    logic                    sz_err_q;
    logic                    inj_tag_q;
    logic                    inj_data_q;
    logic [STLB_TAG_W-1:0]   fmt_tag;
    logic [STLB_DATA_W-1:0]  fmt_data;
    logic                    fmt_sz_err;
    logic [STLB_TAG_W-1:0]   out_tag;
    logic [STLB_DATA_W-1:0]  out_data;

    assign wr_busy = (state != IDLE);

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int i = 0; i < THREADS; i++) tag_acc[i] <= '0;
        end else if (tag_acc_wr_vld) begin
            tag_acc[tag_acc_wr_tid] <= asi_wr_data;
        end
    end

`ifdef LSU_TLB_PERR_INJ_EN
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            inj_tag_q  <= 1'b0;
            inj_data_q <= 1'b0;
        end else if (state == IDLE && data_wr_vld) begin
            inj_tag_q  <= perr_inj_tag;
            inj_data_q <= perr_inj_data;
        end
    end
`else
    assign inj_tag_q  = 1'b0;
    assign inj_data_q = 1'b0;
`endif

    lsu_tlb_wr_fmt u_fmt (
        .data    (data_q),
        .tag_acc (tacc_q),
        .tag     (fmt_tag),
        .dword   (fmt_data),
        .sz_err  (fmt_sz_err)
    );

    always_comb begin
        out_tag                    = fmt_tag;
        out_data                   = fmt_data;
        out_tag[STLB_TAG_PARITY]   = fmt_tag[STLB_TAG_PARITY] ^ inj_tag_q;
        out_data[STLB_DATA_PARITY] = fmt_data[STLB_DATA_PARITY] ^ inj_data_q;
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state          <= IDLE;
            data_q         <= '0;
            tacc_q         <= '0;
            idx_q          <= '0;
            acc_q          <= 1'b0;
            sz_err_q       <= 1'b0;
            tlb_wr_vld     <= 1'b0;
            tlb_wr_tag     <= '0;
            tlb_wr_data    <= '0;
            tlb_wr_idx     <= '0;
            tlb_wr_idx_vld <= 1'b0;
            tlb_wr_done    <= 1'b0;
            tlb_wr_sz_err  <= 1'b0;
        end else begin
            tlb_wr_done   <= 1'b0;
            tlb_wr_sz_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Nonblocking read of tag_acc yields the pre-write value on a same-cycle update.
                    if (data_wr_vld) begin
                        data_q <= asi_wr_data;
                        tacc_q <= tag_acc[data_wr_tid];
                        idx_q  <= data_wr_idx;
                        acc_q  <= data_wr_acc;
                        state  <= FMT;
                    end
                end
                FMT: begin
                    tlb_wr_tag     <= out_tag;
                    tlb_wr_data    <= out_data;
                    tlb_wr_idx     <= idx_q;
                    tlb_wr_idx_vld <= acc_q;
                    sz_err_q       <= fmt_sz_err;
                    tlb_wr_vld     <= 1'b1;
                    state          <= REQ;
                end
                REQ: begin
                    if (tlb_wr_rdy) begin
                        tlb_wr_vld    <= 1'b0;
                        tlb_wr_done   <= 1'b1;
                        tlb_wr_sz_err <= sz_err_q;
                        state         <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_tlb_wrdp.sv
// Scoreboard bench for lsu_tlb_wrdp: randomized ASI stores checked against a field-level reference model.
`timescale 1ns/1ps
module tb_lsu_tlb_wrdp;

    localparam int THREADS = 4;
    localparam int TID_W   = 2;
    localparam int IDX_W   = 6;

    logic              rclk = 1'b0;
    logic              arst_l = 1'b0;
    logic              tag_acc_wr_vld = 1'b0;
    logic [TID_W-1:0]  tag_acc_wr_tid = '0;
    logic [63:0]       asi_wr_data = '0;
    logic              data_wr_vld = 1'b0;
    logic [TID_W-1:0]  data_wr_tid = '0;
    logic              data_wr_acc = 1'b0;
    logic [IDX_W-1:0]  data_wr_idx = '0;
    logic              wr_busy;
    logic              tlb_wr_vld;
    logic              tlb_wr_rdy = 1'b0;
    logic [58:0]       tlb_wr_tag;
    logic [42:0]       tlb_wr_data;
    logic [IDX_W-1:0]  tlb_wr_idx;
    logic              tlb_wr_idx_vld;
    logic              tlb_wr_done;
    logic              tlb_wr_sz_err;
`ifdef LSU_TLB_PERR_INJ_EN
    logic              perr_inj_tag = 1'b0;
    logic              perr_inj_data = 1'b0;
`endif

    lsu_tlb_wrdp #(.THREADS(THREADS), .TID_W(TID_W), .IDX_W(IDX_W)) dut (
        .rclk           (rclk),
        .arst_l         (arst_l),
        .tag_acc_wr_vld (tag_acc_wr_vld),
        .tag_acc_wr_tid (tag_acc_wr_tid),
        .asi_wr_data    (asi_wr_data),
        .data_wr_vld    (data_wr_vld),
        .data_wr_tid    (data_wr_tid),
        .data_wr_acc    (data_wr_acc),
        .data_wr_idx    (data_wr_idx),
        .wr_busy        (wr_busy),
        .tlb_wr_vld     (tlb_wr_vld),
        .tlb_wr_rdy     (tlb_wr_rdy),
        .tlb_wr_tag     (tlb_wr_tag),
        .tlb_wr_data    (tlb_wr_data),
        .tlb_wr_idx     (tlb_wr_idx),
        .tlb_wr_idx_vld (tlb_wr_idx_vld),
        .tlb_wr_done    (tlb_wr_done),
        .tlb_wr_sz_err  (tlb_wr_sz_err)
`ifdef LSU_TLB_PERR_INJ_EN
        ,
        .perr_inj_tag   (perr_inj_tag),
        .perr_inj_data  (perr_inj_data)
`endif
    );

    typedef struct packed {
        logic [58:0]      tag;
        logic [42:0]      data;
        logic [IDX_W-1:0] idx;
        logic             idx_vld;
        logic             sz_err;
        logic [31:0]      cyc;
    } exp_t;

    exp_t         exp_q[$];
    logic [63:0]  tacc_m [THREADS];
    int           tests = 0;
    int           fails = 0;
    int unsigned  cyc = 0;
    int           rdy_mode = 0;   // 0 random, 1 held low, 2 held high
    logic         active = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 rclk = ~rclk;
    always @(posedge rclk) cyc++;

    initial begin
        forever begin
            @(posedge rclk);
            #1;
            case (rdy_mode)
                1:       tlb_wr_rdy = 1'b0;
                2:       tlb_wr_rdy = 1'b1;
                default: tlb_wr_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2:0] page_sel(input logic [63:0] d, output logic reserved);
        logic [2:0] code;
        code = {d[48], d[62:61]};
        reserved = 1'b0;
        case (code)
            3'd0:    page_sel = 3'b000;   // 8K
            3'd1:    page_sel = 3'b001;   // 64K
            3'd3:    page_sel = 3'b011;   // 4M
            3'd5:    page_sel = 3'b111;   // 256M
            default: begin page_sel = 3'b000; reserved = 1'b1; end
        endcase
    endfunction

    function automatic logic [58:0] model_tag(input logic [63:0] d, input logic [63:0] ta, input logic inj);
        logic [58:0] t;
        logic [2:0]  s;
        logic        r;
        logic        p;
        s = page_sel(d, r);
        t = '0;
        t[58]    = d[63];
        t[57:55] = s;
        t[53:28] = ta[47:22];
        t[21:13] = ta[21:13];
        t[12:0]  = ta[12:0];
        p = 1'b0;
        for (int i = 0; i < 59; i++)
            if (i != 54 && i != 26 && i != 24) p = p ^ t[i];
        t[54] = p ^ inj;
        return t;
    endfunction

    function automatic logic [42:0] model_data(input logic [63:0] d, input logic inj);
        logic [42:0] w;
        logic [2:0]  s;
        logic        r;
        s = page_sel(d, r);
        w = '0;
        w[41]    = d[60];
        w[40]    = d[59];
        w[39:13] = d[39:13];
        w[12:10] = s;
        w[5:0]   = d[6:1];
        w[42]    = (^w[41:0]) ^ inj;
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        while ((wr_busy || exp_q.size() != 0 || active) && n < 300) begin
            @(posedge rclk);
            #1;
            n++;
        end
        check("wait_idle_timeout", 64'(n >= 300), 64'd0);
    endtask

    task automatic tag_write(input logic [TID_W-1:0] tid, input logic [63:0] val);
        @(posedge rclk);
        #1;
        tag_acc_wr_vld = 1'b1;
        tag_acc_wr_tid = tid;
        asi_wr_data    = val;
        tacc_m[tid]    = val;
        @(posedge rclk);
        #1;
        tag_acc_wr_vld = 1'b0;
        asi_wr_data    = {$urandom, $urandom};
    endtask

    task automatic do_write(input logic [TID_W-1:0] tid, input logic [63:0] d, input logic acc,
                            input logic [IDX_W-1:0] idx, input logic tw_en, input logic [TID_W-1:0] tw_tid,
                            input logic inj_t, input logic inj_d);
        exp_t e;
        logic r;
        logic it;
        logic id;
        int   n = 0;
        @(posedge rclk);
        #1;
        while (wr_busy && n < 300) begin
            @(posedge rclk);
            #1;
            n++;
        end
        check("busy_timeout", 64'(n >= 300), 64'd0);
        it = 1'b0;
        id = 1'b0;
`ifdef LSU_TLB_PERR_INJ_EN
        it = inj_t;
        id = inj_d;
        perr_inj_tag  = inj_t;
        perr_inj_data = inj_d;
`endif
        e.tag     = model_tag(d, tacc_m[tid], it);
        e.data    = model_data(d, id);
        e.idx     = idx;
        e.idx_vld = acc;
        void'(page_sel(d, r));
        e.sz_err  = r;
        e.cyc     = cyc + 2;
        exp_q.push_back(e);
        data_wr_vld = 1'b1;
        data_wr_tid = tid;
        data_wr_acc = acc;
        data_wr_idx = idx;
        asi_wr_data = d;
        if (tw_en) begin
            tag_acc_wr_vld = 1'b1;
            tag_acc_wr_tid = tw_tid;
            tacc_m[tw_tid] = d;
        end
        @(posedge rclk);
        #1;
        data_wr_vld    = 1'b0;
        tag_acc_wr_vld = 1'b0;
        data_wr_idx    = 6'($urandom_range(0, 63));
        asi_wr_data    = {$urandom, $urandom};
`ifdef LSU_TLB_PERR_INJ_EN
        perr_inj_tag  = 1'b0;
        perr_inj_data = 1'b0;
`endif
    endtask

    task automatic wait_req();
        int n = 0;
        while (!tlb_wr_vld && n < 20) begin
            @(negedge rclk);
            n++;
        end
        check("req_timeout", 64'(tlb_wr_vld), 64'd1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t cur;
        int   done_due = -1;
        logic exp_sz = 1'b0;
        cur = '0;
        forever begin
            @(negedge rclk);
            if (!arst_l) begin
                active   = 1'b0;
                done_due = -1;
            end else begin
                check("vld_while_busy", 64'(data_wr_vld & wr_busy), 64'd0);
                if (tlb_wr_vld) begin
                    if (!active) begin
                        if (exp_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_req: got tlb_wr_vld=1 expected no request");
                        end else begin
                            cur    = exp_q.pop_front();
                            active = 1'b1;
                            check("req_latency", 64'(cyc), 64'(cur.cyc));
                        end
                    end
                    if (active) begin
                        check("tag", 64'(tlb_wr_tag), 64'(cur.tag));
                        check("data", 64'(tlb_wr_data), 64'(cur.data));
                        check("idx_vld", 64'(tlb_wr_idx_vld), 64'(cur.idx_vld));
                        if (cur.idx_vld) check("idx", 64'(tlb_wr_idx), 64'(cur.idx));
                        check("busy_in_req", 64'(wr_busy), 64'd1);
                        if (tlb_wr_rdy) begin
                            active   = 1'b0;
                            done_due = int'(cyc) + 1;
                            exp_sz   = cur.sz_err;
                        end
                    end
                end
                if (done_due == int'(cyc)) begin
                    check("done_pulse", 64'(tlb_wr_done), 64'd1);
                    check("sz_err_pulse", 64'(tlb_wr_sz_err), 64'(exp_sz));
                    check("busy_in_done", 64'(wr_busy), 64'd1);
                    check("vld_after_hs", 64'(tlb_wr_vld), 64'd0);
                end else begin
                    check("no_done", 64'(tlb_wr_done), 64'd0);
                    check("no_sz_err", 64'(tlb_wr_sz_err), 64'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < THREADS; i++) tacc_m[i] = '0;
        #3;
        check("rst_vld", 64'(tlb_wr_vld), 64'd0);
        check("rst_busy", 64'(wr_busy), 64'd0);
        check("rst_done", 64'(tlb_wr_done), 64'd0);
        check("rst_sz_err", 64'(tlb_wr_sz_err), 64'd0);
        check("rst_tag", 64'(tlb_wr_tag), 64'd0);
        check("rst_data", 64'(tlb_wr_data), 64'd0);
        check("rst_idx", 64'(tlb_wr_idx), 64'd0);
        check("rst_idx_vld", 64'(tlb_wr_idx_vld), 64'd0);
        #19;
        arst_l = 1'b1;

        // Data-In, 64K page, tid1
        rdy_mode = 2;
        tag_write(2'd1, 64'h0000_1234_5678_A005);
        do_write(2'd1, 64'hA000_00AB_CDEF_E07E, 1'b0, 6'h11, 1'b0, 2'd0, 1'b0, 1'b0);
        wait_idle();

        // Data-Access idx 0x2A, 256M page
        do_write(2'd1, 64'hA001_0055_4321_807E, 1'b1, 6'h2A, 1'b0, 2'd0, 1'b0, 1'b0);
        wait_idle();

        // Reserved size 110
        do_write(2'd1, 64'hC001_0000_1234_5678, 1'b0, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        wait_idle();

        // rdy held low for 5 cycles while the request is pending
        rdy_mode = 1;
        do_write(2'd1, 64'hE000_0012_3456_789A, 1'b1, 6'h05, 1'b0, 2'd0, 1'b0, 1'b0);
        wait_req();
        repeat (5) begin
            @(negedge rclk);
            check("stall_vld_held", 64'(tlb_wr_vld), 64'd1);
            check("stall_busy", 64'(wr_busy), 64'd1);
        end
        rdy_mode = 2;
        wait_idle();

        // Same-cycle Tag-Access write on tid0: old value used, new value used next time
        tag_write(2'd0, 64'h0000_7777_8888_9999);
        do_write(2'd0, 64'h8000_4444_5555_6666, 1'b0, 6'h00, 1'b1, 2'd0, 1'b0, 1'b0);
        wait_idle();
        do_write(2'd0, 64'hA000_0000_0F0F_F0F0, 1'b0, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        wait_idle();

`ifdef LSU_TLB_PERR_INJ_EN
        do_write(2'd1, 64'hA000_00AB_CDEF_E07E, 1'b0, 6'h00, 1'b0, 2'd0, 1'b0, 1'b1);
        wait_idle();
        do_write(2'd1, 64'h8000_0000_1111_2222, 1'b0, 6'h00, 1'b0, 2'd0, 1'b1, 1'b0);
        wait_idle();
`endif

        // Reset while in REQ
        rdy_mode = 1;
        do_write(2'd2, 64'hA000_0033_2211_0044, 1'b1, 6'h3F, 1'b0, 2'd0, 1'b0, 1'b0);
        wait_req();
        #2;
        arst_l = 1'b0;
        #1;
        check("arst_vld_drop", 64'(tlb_wr_vld), 64'd0);
        check("arst_busy_drop", 64'(wr_busy), 64'd0);
        check("arst_no_done", 64'(tlb_wr_done), 64'd0);
        for (int i = 0; i < THREADS; i++) tacc_m[i] = '0;
        repeat (2) @(negedge rclk);
        #2;
        arst_l = 1'b1;
        rdy_mode = 0;
        repeat (3) @(negedge rclk);
        check("idle_after_reset", 64'(wr_busy), 64'd0);
        do_write(2'd1, 64'hA000_00AB_CDEF_E07E, 1'b0, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        wait_idle();

        // Randomized traffic with interleaved Tag-Access writes
        for (int k = 0; k < 40; k++) begin
            logic [63:0] d;
            logic [2:0]  code;
            d    = {$urandom, $urandom};
            code = 3'($urandom_range(0, 7));
            d[48]    = code[2];
            d[62:61] = code[1:0];
            do_write(2'($urandom_range(0, 3)), d, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                     ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0)
                tag_write(2'($urandom_range(0, 3)), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();
        repeat (3) @(negedge rclk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 400000ns");
        $fatal(1, "watchdog");
    end

endmodule
